// File: rtl/ula_muldiv_ctrl_pkg.sv
// Shared encodings for the EX-stage ALU control and HI/LO mul/div unit.
package ula_pkg;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SLL  = 4'b0011;
    localparam logic [3:0] OP_SRA  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_LUI  = 4'b1000;
    localparam logic [3:0] OP_SRAV = 4'b1010;
    localparam logic [3:0] OP_AUX  = 4'b1011;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_XOR  = 4'b1101;
    localparam logic [3:0] OP_SLLV = 4'b1110;
    localparam logic [3:0] OP_SRLV = 4'b1111;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_RTYPE = 4'b0010;
    localparam logic [3:0] ALU_SLT   = 4'b0011;
    localparam logic [3:0] ALU_AND   = 4'b0100;
    localparam logic [3:0] ALU_OR    = 4'b0101;
    localparam logic [3:0] ALU_XOR   = 4'b0110;
    localparam logic [3:0] ALU_AUX   = 4'b0111;
    localparam logic [3:0] ALU_LUI   = 4'b1000;

    localparam logic [5:0] F_SLL   = 6'b000000;
    localparam logic [5:0] F_SRL   = 6'b000010;
    localparam logic [5:0] F_SRA   = 6'b000011;
    localparam logic [5:0] F_SLLV  = 6'b000100;
    localparam logic [5:0] F_SRLV  = 6'b000110;
    localparam logic [5:0] F_SRAV  = 6'b000111;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_XOR   = 6'b100110;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SLTU  = 6'b101011;

    typedef enum logic [1:0] {
        MF_ULA = 2'b00,
        MF_HI  = 2'b01,
        MF_LO  = 2'b10
    } mf_sel_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIX,
        ST_DONE
    } state_e;

    // Matches func[1:0] of the MULT/MULTU/DIV/DIVU group.
    typedef enum logic [1:0] {
        K_MULT  = 2'b00,
        K_MULTU = 2'b01,
        K_DIV   = 2'b10,
        K_DIVU  = 2'b11
    } kind_e;

endpackage

// File: rtl/ula_muldiv_ctrl_if.sv
// EX-stage bundle between the pipeline and the ALU control / HI-LO unit.
interface ula_muldiv_ctrl_if #(parameter int DATA_W = 32);
    logic              valid;
    logic [3:0]        AluOp;
    logic [5:0]        func;
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;
    logic [3:0]        op;
    logic              stall;
    logic [1:0]        mf_sel;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;

    modport master (
        output valid, AluOp, func, rs_val, rt_val,
        input  op, stall, mf_sel, hi, lo
    );

    modport slave (
        input  valid, AluOp, func, rs_val, rt_val,
        output op, stall, mf_sel, hi, lo
    );
endinterface

// File: rtl/ula_muldiv_ctrl_core.sv
// Iterative shift-add multiplier / restoring divider with HI/LO registers.
module ula_muldiv_core
    import ula_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  kind_e             i_kind,
    input  logic [DATA_W-1:0] i_rs,
    input  logic [DATA_W-1:0] i_rt,
    input  logic              i_step,
    input  logic              i_fix,
    input  logic              i_mthi,
    input  logic              i_mtlo,
    output logic              o_done,
    output logic [DATA_W-1:0] o_hi,
    output logic [DATA_W-1:0] o_lo
);
    localparam int CW = $clog2(DATA_W) + 1;

    logic [DATA_W-1:0]   r_a;
    logic [2*DATA_W-1:0] r_acc;
    logic [DATA_W-1:0]   r_rem;
    logic [CW-1:0]       r_cnt;
    logic                r_srs;
    logic                r_srt;
    logic                r_div;
    logic [DATA_W-1:0]   r_hi;
    logic [DATA_W-1:0]   r_lo;

    logic                w_signed;
    logic                w_is_div;
    logic                w_rs_neg;
    logic                w_rt_neg;
    logic [DATA_W-1:0]   w_rs_mag;
    logic [DATA_W-1:0]   w_rt_mag;
    logic [DATA_W:0]     w_sum;
    logic [DATA_W:0]     w_shl;
    logic [DATA_W:0]     w_trial;
    logic                w_ge;
    logic [2*DATA_W-1:0] w_prod;
    logic [DATA_W-1:0]   w_quo;
    logic [DATA_W-1:0]   w_rem;

    assign w_signed = (i_kind == K_MULT) || (i_kind == K_DIV);
    assign w_is_div = (i_kind == K_DIV) || (i_kind == K_DIVU);
    assign w_rs_neg = w_signed & i_rs[DATA_W-1];
    assign w_rt_neg = w_signed & i_rt[DATA_W-1];
    assign w_rs_mag = w_rs_neg ? -i_rs : i_rs;
    assign w_rt_mag = w_rt_neg ? -i_rt : i_rt;

    // Multiply: upper half accumulates, multiplier bits shift out of the bottom.
    assign w_sum = {1'b0, r_acc[2*DATA_W-1:DATA_W]}
                 + (r_acc[0] ? {1'b0, r_a} : '0);

    // Divide: quotient bits shift into acc[DATA_W-1:0] as dividend bits leave.
    assign w_shl   = {r_rem, r_acc[DATA_W-1]};
    assign w_trial = w_shl - {1'b0, r_a};
    assign w_ge    = ~w_trial[DATA_W];

    assign w_prod = (r_srs ^ r_srt) ? -r_acc : r_acc;
    assign w_quo  = (r_srs ^ r_srt) ? -r_acc[DATA_W-1:0] : r_acc[DATA_W-1:0];
    assign w_rem  = r_srs ? -r_rem : r_rem;

    assign o_done = (r_cnt == CW'(DATA_W - 1));
    assign o_hi   = r_hi;
    assign o_lo   = r_lo;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_a   <= '0;
            r_acc <= '0;
            r_rem <= '0;
            r_cnt <= '0;
            r_srs <= 1'b0;
            r_srt <= 1'b0;
            r_div <= 1'b0;
            r_hi  <= '0;
            r_lo  <= '0;
        end else begin
            if (i_start) begin
                r_cnt <= '0;
                r_div <= w_is_div;
                r_srs <= w_rs_neg;
                r_srt <= w_rt_neg;
                r_rem <= '0;
                r_a   <= w_is_div ? w_rt_mag : w_rs_mag;
                r_acc <= {{DATA_W{1'b0}}, w_is_div ? w_rs_mag : w_rt_mag};
                if (w_is_div && (i_rt == '0)) begin
                    r_hi <= i_rs;
                    r_lo <= '1;
                end
            end else if (i_step) begin
                r_cnt <= r_cnt + CW'(1);
                if (r_div) begin
                    r_rem <= w_ge ? w_trial[DATA_W-1:0] : w_shl[DATA_W-1:0];
                    r_acc[DATA_W-1:0] <= {r_acc[DATA_W-2:0], w_ge};
                end else begin
                    r_acc <= {w_sum, r_acc[DATA_W-1:1]};
                end
            end else if (i_fix) begin
                if (r_div) begin
                    r_hi <= w_rem;
                    r_lo <= w_quo;
                end else begin
                    r_hi <= w_prod[2*DATA_W-1:DATA_W];
                    r_lo <= w_prod[DATA_W-1:0];
                end
            end
            if (i_mthi) r_hi <= i_rs;
            if (i_mtlo) r_lo <= i_rs;
        end
    end

endmodule

// File: rtl/ula_muldiv_ctrl.sv
// ALU op decode plus sequencer, stall and result select for the HI/LO unit.
module ula_muldiv_ctrl
    import ula_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic         clock,
    input  logic         reset,
    ula_muldiv_ctrl_if.slave bus
);
    state_e     r_state;
    state_e     w_next;
    logic [3:0] w_op;
    logic       w_rtype;
    logic       w_muldiv;
    logic       w_start;
    logic       w_stall;
    logic       w_step;
    logic       w_done;
    mf_sel_e    w_mf;

    assign w_rtype  = (bus.AluOp == ALU_RTYPE);
    assign w_muldiv = w_rtype && (bus.func[5:2] == F_MULT[5:2]);
    assign w_start  = bus.valid && w_muldiv && (r_state == ST_IDLE);
    assign w_step   = (r_state == ST_MUL) || (r_state == ST_DIV);
    assign w_stall  = w_start || w_step || (r_state == ST_FIX);

    always_comb begin
        w_op = OP_AND;
        case (bus.AluOp)
            ALU_ADD: w_op = OP_ADD;
            ALU_SUB: w_op = OP_SUB;
            ALU_SLT: w_op = OP_SLT;
            ALU_LUI: w_op = OP_LUI;
            ALU_AND: w_op = OP_AND;
            ALU_OR:  w_op = OP_OR;
            ALU_XOR: w_op = OP_XOR;
            ALU_AUX: w_op = OP_AUX;
            ALU_RTYPE: begin
                case (bus.func)
                    F_SLLV:         w_op = OP_SLLV;
                    F_SRLV:         w_op = OP_SRLV;
                    F_SRAV:         w_op = OP_SRAV;
                    F_SRA:          w_op = OP_SRA;
                    F_SRL:          w_op = OP_SRL;
                    F_SLL:          w_op = OP_SLL;
                    F_ADD:          w_op = OP_ADD;
                    F_SUB:          w_op = OP_SUB;
                    F_AND:          w_op = OP_AND;
                    F_OR:           w_op = OP_OR;
                    F_XOR:          w_op = OP_XOR;
                    F_NOR:          w_op = OP_NOR;
                    F_SLT, F_SLTU:  w_op = OP_SLT;
                    default:        w_op = OP_AND;
                endcase
            end
            default: w_op = OP_AND;
        endcase
    end

    always_comb begin
        w_mf = MF_ULA;
        if (w_rtype && (bus.func == F_MFHI)) w_mf = MF_HI;
        if (w_rtype && (bus.func == F_MFLO)) w_mf = MF_LO;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    if (!bus.func[1])            w_next = ST_MUL;
                    else if (bus.rt_val == '0)   w_next = ST_DONE;
                    else                         w_next = ST_DIV;
                end
            end
            ST_MUL, ST_DIV: if (w_done) w_next = ST_FIX;
            ST_FIX:  w_next = ST_DONE;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    ula_muldiv_core #(.DATA_W(DATA_W)) u_core (
        .i_clk   (clock),
        .i_rst   (reset),
        .i_start (w_start),
        .i_kind  (kind_e'(bus.func[1:0])),
        .i_rs    (bus.rs_val),
        .i_rt    (bus.rt_val),
        .i_step  (w_step),
        .i_fix   (r_state == ST_FIX),
        .i_mthi  (bus.valid && !w_stall && w_rtype && (bus.func == F_MTHI)),
        .i_mtlo  (bus.valid && !w_stall && w_rtype && (bus.func == F_MTLO)),
        .o_done  (w_done),
        .o_hi    (bus.hi),
        .o_lo    (bus.lo)
    );

    assign bus.op     = w_op;
    assign bus.stall  = w_stall;
    assign bus.mf_sel = w_mf;

endmodule

// File: tb/tb_ula_muldiv_ctrl.sv
// Self-checking bench: decode table, HI/LO moves, mul/div against an arithmetic model.
module tb_ula_muldiv_ctrl;

    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    ula_muldiv_ctrl_if #(.DATA_W(32)) bus ();

    ula_muldiv_ctrl #(.DATA_W(32)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    function automatic void ref_muldiv(input logic [5:0] f,
                                       input logic [31:0] a, input logic [31:0] b,
                                       output logic [31:0] h, output logic [31:0] l);
        logic [63:0] p;
        int sa, sb;
        h = '0;
        l = '0;
        sa = $signed(a);
        sb = $signed(b);
        if (f == F_MULT) begin
            p = longint'(sa) * longint'(sb);
            h = p[63:32];
            l = p[31:0];
        end else if (f == F_MULTU) begin
            p = {32'b0, a} * {32'b0, b};
            h = p[63:32];
            l = p[31:0];
        end else if (b == 32'd0) begin
            h = a;
            l = 32'hFFFF_FFFF;
        end else if (f == F_DIVU) begin
            l = a / b;
            h = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            l = 32'h8000_0000;
            h = 32'h0;
        end else begin
            l = sa / sb;
            h = sa % sb;
        end
    endfunction

    task automatic drive(input logic v, input logic [3:0] alu, input logic [5:0] f,
                         input logic [31:0] a, input logic [31:0] b);
        bus.valid  = v;
        bus.AluOp  = alu;
        bus.func   = f;
        bus.rs_val = a;
        bus.rt_val = b;
    endtask

    task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] eh, el;
        int n, en;
        ref_muldiv(f, a, b, eh, el);
        en = (f[1] && b == 32'd0) ? 1 : 34;
        @(negedge clk);
        drive(1'b1, 4'b0010, f, a, b);
        #1;
        checks++;
        if (bus.op !== 4'b0000 || bus.mf_sel !== 2'b00) begin
            errors++;
            $display("FAIL muldiv_decode f=%b op=%b mf=%b want op=0000 mf=00", f, bus.op, bus.mf_sel);
        end
        n = 0;
        while (bus.stall === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
            #1;
        end
        checks++;
        if (n !== en) begin
            errors++;
            $display("FAIL stall_len f=%b a=%h b=%h got %0d want %0d", f, a, b, n, en);
        end
        checks++;
        if (bus.hi !== eh || bus.lo !== el) begin
            errors++;
            $display("FAIL hilo f=%b a=%h b=%h got hi=%h lo=%h want hi=%h lo=%h",
                     f, a, b, bus.hi, bus.lo, eh, el);
        end
    endtask

    task automatic test_reset();
        drive(1'b0, 4'b0010, F_MFLO, 32'h0, 32'h0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (bus.stall !== 1'b0 || bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
            errors++;
            $display("FAIL reset_state stall=%b hi=%h lo=%h want 0/0/0", bus.stall, bus.hi, bus.lo);
        end
        checks++;
        if (bus.mf_sel !== 2'b10 || bus.op !== 4'b0000) begin
            errors++;
            $display("FAIL reset_comb mf=%b op=%b want 10/0000", bus.mf_sel, bus.op);
        end
        bus.AluOp = 4'b0000;
        #1;
        checks++;
        if (bus.op !== 4'b0010) begin
            errors++;
            $display("FAIL reset_op got %b want 0010", bus.op);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_decode();
        logic [13:0] tbl [35];
        logic [13:0] e;
        logic [3:0] alu, eop;
        logic [5:0] f;
        logic [1:0] emf;
        tbl = '{
            {4'b0000, 6'h00, 4'b0010}, {4'b0001, 6'h00, 4'b0110},
            {4'b0011, 6'h00, 4'b0111}, {4'b1000, 6'h00, 4'b1000},
            {4'b0100, 6'h00, 4'b0000}, {4'b0101, 6'h00, 4'b0001},
            {4'b0110, 6'h00, 4'b1101}, {4'b0111, 6'h2A, 4'b1011},
            {4'b1111, 6'h20, 4'b0000}, {4'b1001, 6'h00, 4'b0000},
            {4'b0010, 6'b000100, 4'b1110}, {4'b0010, 6'b000110, 4'b1111},
            {4'b0010, 6'b000111, 4'b1010}, {4'b0010, 6'b000011, 4'b0100},
            {4'b0010, 6'b000010, 4'b0101}, {4'b0010, 6'b000000, 4'b0011},
            {4'b0010, 6'b100000, 4'b0010}, {4'b0010, 6'b100010, 4'b0110},
            {4'b0010, 6'b100100, 4'b0000}, {4'b0010, 6'b100101, 4'b0001},
            {4'b0010, 6'b100110, 4'b1101}, {4'b0010, 6'b100111, 4'b1100},
            {4'b0010, 6'b101010, 4'b0111}, {4'b0010, 6'b101011, 4'b0111},
            {4'b0010, F_MULT, 4'b0000},    {4'b0010, F_MULTU, 4'b0000},
            {4'b0010, F_DIV, 4'b0000},     {4'b0010, F_DIVU, 4'b0000},
            {4'b0010, F_MFHI, 4'b0000},    {4'b0010, F_MTHI, 4'b0000},
            {4'b0010, F_MFLO, 4'b0000},    {4'b0010, F_MTLO, 4'b0000},
            {4'b0010, 6'b111111, 4'b0000}, {4'b0010, 6'b000001, 4'b0000},
            {4'b0000, F_MFHI, 4'b0010}
        };
        for (int i = 0; i < 35; i++) begin
            e = tbl[i];
            alu = e[13:10];
            f = e[9:4];
            eop = e[3:0];
            emf = (alu == 4'b0010 && f == F_MFHI) ? 2'b01 :
                  (alu == 4'b0010 && f == F_MFLO) ? 2'b10 : 2'b00;
            @(negedge clk);
            drive(!(alu == 4'b0010 && f[5:2] == 4'b0110), alu, f, $urandom, $urandom);
            #1;
            checks++;
            if (bus.op !== eop || bus.stall !== 1'b0 || bus.mf_sel !== emf) begin
                errors++;
                $display("FAIL decode alu=%b f=%b got op=%b stall=%b mf=%b want op=%b stall=0 mf=%b",
                         alu, f, bus.op, bus.stall, bus.mf_sel, eop, emf);
            end
        end
        @(negedge clk);
        bus.valid = 1'b0;
    endtask

    task automatic test_move();
        @(negedge clk);
        drive(1'b1, 4'b0010, F_MTHI, 32'hDEAD_BEEF, 32'h0);
        #1;
        checks++;
        if (bus.stall !== 1'b0) begin
            errors++;
            $display("FAIL mthi_stall got %b want 0", bus.stall);
        end
        @(negedge clk);
        drive(1'b1, 4'b0010, F_MFHI, 32'h0, 32'h0);
        #1;
        checks++;
        if (bus.hi !== 32'hDEAD_BEEF || bus.mf_sel !== 2'b01 || bus.stall !== 1'b0) begin
            errors++;
            $display("FAIL mfhi got hi=%h mf=%b stall=%b want DEADBEEF/01/0", bus.hi, bus.mf_sel, bus.stall);
        end
        @(negedge clk);
        drive(1'b1, 4'b0010, F_MTLO, 32'h1, 32'h0);
        @(negedge clk);
        drive(1'b1, 4'b0010, F_MFLO, 32'h0, 32'h0);
        #1;
        checks++;
        if (bus.lo !== 32'h1 || bus.mf_sel !== 2'b10 || bus.hi !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL mflo got lo=%h mf=%b hi=%h want 1/10/DEADBEEF", bus.lo, bus.mf_sel, bus.hi);
        end
        @(negedge clk);
        bus.valid = 1'b0;
    endtask

    task automatic test_muldiv_directed();
        run_op(F_MULT, 32'hFFFF_FFFD, 32'h0000_0007);
        run_op(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(F_DIVU, 32'd100, 32'd7);
        run_op(F_DIV, 32'hFFFF_FFF9, 32'h2);
        run_op(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(F_DIV, 32'h5, 32'h0);
        run_op(F_MULT, 32'h8000_0000, 32'h8000_0000);
        run_op(F_DIV, 32'h7, 32'hFFFF_FFFE);
        @(negedge clk);
        bus.valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [5:0] f;
        logic [31:0] a, b;
        for (int i = 0; i < 24; i++) begin
            f = {4'b0110, 2'($urandom_range(0, 3))};
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                default: ;
            endcase
            run_op(f, a, b);
        end
        @(negedge clk);
        bus.valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        drive(1'b1, 4'b0010, F_MTHI, 32'h1234_5678, 32'h0);
        @(negedge clk);
        drive(1'b1, 4'b0010, F_MTLO, 32'h9ABC_DEF0, 32'h0);
        @(negedge clk);
        drive(1'b1, 4'b0010, F_MULT, 32'h0000_1234, 32'h0000_5678);
        repeat (11) @(posedge clk);
        #2;
        checks++;
        if (bus.stall !== 1'b1) begin
            errors++;
            $display("FAIL mid_busy stall got %b want 1", bus.stall);
        end
        bus.valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.stall !== 1'b0 || bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset got stall=%b hi=%h lo=%h want 0/0/0", bus.stall, bus.hi, bus.lo);
        end
        @(negedge clk);
        rst = 1'b0;
        run_op(F_MULTU, 32'd3, 32'd5);
        @(negedge clk);
        bus.valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_decode();
        test_move();
        test_muldiv_directed();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ula_muldiv_ctrl.md
# ula_muldiv_ctrl

Next-generation ALU control for the MIPS datapath. It keeps the existing single-cycle AluOp/func → 4-bit ULA op decode and adds a HI/LO multiply/divide unit with a multi-cycle sequencer. MULT/MULTU/DIV/DIVU run iteratively over DATA_W cycles and hold the pipeline with a stall. MFHI/MFLO/MTHI/MTLO are single-cycle. The block sits in EX, beside the ULA, and feeds the EX result mux.

## Interface
- DATA_W, 32, operand/HI/LO width (even, ≥ 8)
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state
- valid  in  1  EX holds a live instruction
- AluOp  in  4  main-control ALU class
- func  in  6  R-type funct field
- rs_val  in  DATA_W  first operand (dividend / multiplicand / MTHI-MTLO source)
- rt_val  in  DATA_W  second operand
- op  out  4  ULA operation code (combinational)
- stall  out  1  hold PC/IF/ID/EX; EX instruction re-presented unchanged
- mf_sel  out  2  EX result select: 00 ULA, 01 HI, 10 LO
- hi  out  DATA_W  HI register
- lo  out  DATA_W  LO register

## Operation
- op decode, unchanged from the current block:
  - AluOp 0000→0010, 0001→0110, 0011→0111, 1000→1000, 0100→0000, 0101→0001, 0110→1101, 0111→1011.
  - AluOp 0010 decodes by func: SLLV 000100→1110, SRLV 000110→1111, SRAV 000111→1010, SRA 000011→0100, SRL 000010→0101, SLL 000000→0011, ADD 100000→0010, SUB 100010→0110, AND 100100→0000, OR 100101→0001, XOR 100110→1101, NOR 100111→1100, SLT/SLTU 101010/101011→0111.
  - Any other value→0000.
- New funcs, under AluOp 0010: MULT 011000, MULTU 011001, DIV 011010, DIVU 011011, MFHI 010000, MTHI 010001, MFLO 010010, MTLO 010011. op=0000 for all of these.
- mf_sel: 01 for MFHI, 10 for MFLO, else 00.
- MTHI/MTLO: when valid & !stall, the next edge loads rs_val into hi/lo.
- "start" = valid & AluOp==0010 & func ∈ {MULT, MULTU, DIV, DIVU} & state==IDLE.
- FSM states: IDLE, MUL, DIV, FIX, DONE.
  - IDLE→MUL on MULT/MULTU start.
  - IDLE→DIV on DIV/DIVU start with rt_val≠0.
  - IDLE→DONE on DIV/DIVU start with rt_val==0.
  - MUL/DIV→FIX after DATA_W iterations.
  - FIX→DONE.
  - DONE→IDLE unconditionally; no restart from DONE even though the same instruction is still presented.
- At start, operands are latched:
  - Signed ops latch magnitudes plus sign flags.
  - Unsigned ops latch raw values with sign flags cleared.
- MUL: shift-add, one multiplier bit per cycle, 2·DATA_W accumulator.
- DIV: restoring division, one quotient bit per cycle, DATA_W+1-bit partial remainder.
- FIX applies sign correction and writes HI/LO:
  - Multiply: product negated if sign_rs^sign_rt; HI=upper half, LO=lower half.
  - Divide: quotient negated if sign_rs^sign_rt; remainder negated if sign_rs; LO=quotient, HI=remainder.
- Most-negative ÷ −1: magnitude arithmetic truncated to DATA_W gives LO=100…0, HI=0. No trap.
- Divide by zero: at the start edge HI=rs_val, LO=all ones.
- valid is sampled only in IDLE. A started operation always completes unless reset.

## Timing
- Reset values: state IDLE, iteration counter 0, hi=0, lo=0, stall=0 (combinational from state), mf_sel/op follow inputs.
- stall = start | (state ∈ {MUL, DIV, FIX}). stall is low in IDLE without start, and low in DONE.
- MULT/DIV: stall high for DATA_W+2 cycles (start cycle + DATA_W iterations + FIX). The instruction retires in the DONE cycle, when hi/lo are already valid.
- Divide by zero: stall high for 1 cycle; retires in DONE.
- MF/MT: zero added latency. An MFHI in the cycle after DONE sees the new HI.
- Async reset mid-operation: state→IDLE and stall→0 immediately, hi/lo→0, partial results discarded.
- Iteration counter width: $clog2(DATA_W)+1. No wrap; it is cleared on start.

## Structure
- Package ula_pkg holds:
  - ULA op codes
  - AluOp class codes
  - funct constants, including the mul/div/move funcs
  - the mf_sel encoding
  - the FSM state encoding
- Sub-module ula_muldiv_core holds the iterative datapath: operand latches, accumulator/remainder, counter, sign fix, HI/LO. It has a start/kind/done interface.
- ula_muldiv_ctrl holds the decode, the FSM, stall and mf_sel.

## Test plan (DATA_W=32)
- Decode: AluOp 0010/func 100010 → op 0110, stall 0. AluOp 0111 → op 1011. AluOp 0010/func 111111 → op 0000.
- MULT rs=FFFFFFFD, rt=00000007 → stall high exactly 34 cycles; in DONE, hi=FFFFFFFF, lo=FFFFFFEB. MULTU FFFFFFFF×FFFFFFFF → hi=FFFFFFFE, lo=00000001.
- DIVU 100/7 → lo=0000000E, hi=00000002. DIV rs=FFFFFFF9 (−7), rt=2 → lo=FFFFFFFD, hi=FFFFFFFF. DIV 80000000/FFFFFFFF → lo=80000000, hi=0.
- DIV rs=5, rt=0 → stall high 1 cycle; hi=00000005, lo=FFFFFFFF.
- MTHI DEADBEEF, then MFHI next cycle → hi=DEADBEEF, mf_sel=01, stall 0. MTLO 1 then MFLO → mf_sel=10, lo=1.
- Reset pulse during MUL iteration 10 → stall=0 and hi=lo=0 before the next edge. A following MULTU 3×5 completes normally → lo=0000000F, hi=0.
